// File: rtl/aes_pkg.sv
// Shared AES-128 definitions used by the iterative core and its round-constant
// generator. It holds the forward S-box, the byte-wise round transforms on a
// 128-bit state, and the GF(2^8) doubling helper. Byte 0 of the state is bits
// [127:120]. Bytes are stored column-major, so byte n is row n%4 of column n/4.
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8). This also advances the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes128(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // Row r of the output takes its column c from column (c+r)%4 of the input.
    function automatic logic [127:0] shift_rows128(input logic [127:0] s);
        logic [127:0] r;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns128(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int col = 0; col < 4; col++) begin
            a0 = s[127-32*col -: 8];
            a1 = s[119-32*col -: 8];
            a2 = s[111-32*col -: 8];
            a3 = s[103-32*col -: 8];
            r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// AES-128 round-constant generator. rc starts at 01. It doubles in GF(2^8)
// on every clock edge, which gives the sequence 01,02,...,80,1b,36.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous active-high reset, rc <= 01
//   load  in  1  restart the sequence, rc <= 01
//   rc    out 8  current round constant (registered)
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    output logic [7:0] rc
);

    // NOTE: registers are written with <= only. This way every flop samples
    // the values from before the edge, whatever the order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst || load)
            rc <= RCON_INIT;
        else
            rc <= xtime(rc);
    end

endmodule

// File: rtl/aes_128_core.sv
// Iterative AES-128 encryption core. It runs one round per clock and expands
// the round key on the fly. An external sequencer pulses first_round to load
// the block and pulses final_round on round 10. The ciphertext is in the state
// register right after the final_round edge.
// Ports:
//   clk          in  1    system clock
//   rst          in  1    synchronous active-high reset
//   data_in      in  128  plaintext, byte 0 = bits[127:120], sampled on first_round
//   key          in  128  cipher key, sampled on first_round
//   first_round  in  1    load state<=data_in^key, key<=key, rc<=01 (wins over final_round)
//   final_round  in  1    this cycle executes round 10 (no MixColumns)
//   rc           out 8    current round constant
//   data_out     out 128  state register
//   done         out 1    only with `AES_DONE_FLAG_EN: 1-cycle pulse with valid ciphertext
module aes_128_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    input  logic         first_round,
    input  logic         final_round,
    output logic [7:0]   rc,
    output logic [127:0] data_out
`ifdef AES_DONE_FLAG_EN
    ,
    output logic         done
`endif
);

    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [127:0] key_next;
    logic [127:0] round_out;
    logic [31:0]  sub_rot;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [127:0] sr_state;

    aes_rcon_gen u_rcon (
        .clk  (clk),
        .rst  (rst),
        .load (first_round),
        .rc   (rc)
    );

    // SubWord(RotWord(w3)). The rotation moves the top byte of w3 to the bottom.
    assign sub_rot = {SBOX[key_q[23:16]], SBOX[key_q[15:8]],
                      SBOX[key_q[7:0]],   SBOX[key_q[31:24]]};

    assign w0_n     = key_q[127:96] ^ sub_rot ^ {rc, 24'h000000};
    assign w1_n     = key_q[95:64]  ^ w0_n;
    assign w2_n     = key_q[63:32]  ^ w1_n;
    assign w3_n     = key_q[31:0]   ^ w2_n;
    assign key_next = {w0_n, w1_n, w2_n, w3_n};

    assign sr_state = shift_rows128(sub_bytes128(state_q));

    always_comb begin
        round_out = mix_columns128(sr_state) ^ key_next;
        if (final_round)
            round_out = sr_state ^ key_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            key_q   <= '0;
        end else if (first_round) begin
            state_q <= data_in ^ key;
            key_q   <= key;
        end else begin
            state_q <= round_out;
            key_q   <= key_next;
        end
    end

    assign data_out = state_q;

`ifdef AES_DONE_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst || first_round)
            done <= 1'b0;
        else
            done <= final_round;
    end
`endif

endmodule

// File: tb/tb_aes_128_core.sv
// Directed testbench for aes_128_core. It uses the FIPS-197 and zero-key
// vectors, the round-constant sequence, reset and restart in mid-operation,
// a load with both strobes high, and back-to-back encryptions.
module tb_aes_128_core;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data_in;
    logic [127:0] key;
    logic         first_round;
    logic         final_round;
    logic [7:0]   rc;
    logic [127:0] data_out;
`ifdef AES_DONE_FLAG_EN
    logic         done;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] RC_EXP [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K3  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P3  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C3  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] X2  = 128'h00102030405060708090a0b0c0d0e0f0;

    aes_128_core dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .key         (key),
        .first_round (first_round),
        .final_round (final_round),
        .rc          (rc),
        .data_out    (data_out)
`ifdef AES_DONE_FLAG_EN
        ,
        .done        (done)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge. Inputs change and outputs are sampled 1 ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_done(input string tag, input logic exp);
`ifdef AES_DONE_FLAG_EN
        check(tag, {127'b0, done}, {127'b0, exp});
`endif
    endtask

    // Full nominal sequence: load, 9 plain rounds, final round, then check the ciphertext.
    task automatic encrypt(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] ct);
        data_in     = pt;
        key         = k;
        first_round = 1'b1;
        final_round = 1'b0;
        tick();
        first_round = 1'b0;
        check_done({tag, "_done_lo_load"}, 1'b0);
        for (int r = 0; r < 9; r++) begin
            check({tag, "_rc"}, {120'b0, rc}, {120'b0, RC_EXP[r]});
            tick();
            check_done({tag, "_done_lo"}, 1'b0);
        end
        check({tag, "_rc10"}, {120'b0, rc}, {120'b0, RC_EXP[9]});
        final_round = 1'b1;
        tick();
        final_round = 1'b0;
        check({tag, "_ct"}, data_out, ct);
        check_done({tag, "_done_hi"}, 1'b1);
    endtask

    // Load and then run n plain rounds without checking anything.
    task automatic partial(input logic [127:0] pt, input logic [127:0] k, input int n);
        data_in     = pt;
        key         = k;
        first_round = 1'b1;
        final_round = 1'b0;
        tick();
        first_round = 1'b0;
        for (int r = 0; r < n; r++) tick();
    endtask

    initial begin
        rst         = 1'b1;
        data_in     = '0;
        key         = '0;
        first_round = 1'b0;
        final_round = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_data", data_out, 128'h0);
        check("reset_rc", {120'b0, rc}, 128'h01);
        check_done("reset_done", 1'b0);

        // Zero key and zero plaintext. This also walks the rc sequence.
        encrypt("zero", 128'h0, 128'h0, C1);

        // Back-to-back: each load comes in the cycle after the ciphertext capture.
        encrypt("fips_c1", P2, K2, C2);
        encrypt("fips_b", P3, K3, C3);

        // Reset during round 5, then restart.
        partial(P2, K2, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_data", data_out, 128'h0);
        check("midrst_rc", {120'b0, rc}, 128'h01);
        check_done("midrst_done", 1'b0);
        encrypt("after_rst", P2, K2, C2);

        // A new first_round in mid-operation restarts with the new block.
        partial(128'h0, 128'h0, 3);
        encrypt("restart", P3, K3, C3);

        // With both strobes high, the load wins.
        data_in     = P2;
        key         = K2;
        first_round = 1'b1;
        final_round = 1'b1;
        tick();
        first_round = 1'b0;
        final_round = 1'b0;
        check("both_load_data", data_out, X2);
        check("both_load_rc", {120'b0, rc}, 128'h01);
        check_done("both_load_done", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
